// File: rtl/seq_alu.sv
// Registered ALU with valid/ready handshakes, one operation in flight.
// Define SEQ_ALU_MUL_EN to build the iterative shift-add multiplier (command 11).
module seq_alu #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       command,
   input  logic [WIDTH-1:0] operandA,
   input  logic [WIDTH-1:0] operandB,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             carryout,
   output logic             overflow,
   output logic             zero,
   output logic             illegal
);

   localparam logic [3:0] C_ADD  = 4'd0;
   localparam logic [3:0] C_SUB  = 4'd1;
   localparam logic [3:0] C_XOR  = 4'd2;
   localparam logic [3:0] C_SLT  = 4'd3;
   localparam logic [3:0] C_AND  = 4'd4;
   localparam logic [3:0] C_NAND = 4'd5;
   localparam logic [3:0] C_NOR  = 4'd6;
   localparam logic [3:0] C_OR   = 4'd7;
   localparam logic [3:0] C_SLL  = 4'd8;
   localparam logic [3:0] C_SRL  = 4'd9;
   localparam logic [3:0] C_SRA  = 4'd10;
`ifdef SEQ_ALU_MUL_EN
   localparam logic [3:0] C_MUL  = 4'd11;
`endif

`ifdef SEQ_ALU_MUL_EN
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_MULT = 2'd1, S_DONE = 2'd2} state_t;
`else
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_DONE = 2'd2} state_t;
`endif

   state_t             state_q;
   logic [WIDTH-1:0]   result_q;
   logic               carry_q;
   logic               ovf_q;
   logic               zero_q;
   logic               ill_q;

   logic               accept;
   logic [WIDTH-1:0]   res_d;
   logic               carry_d;
   logic               ovf_d;
   logic               ill_d;
   logic               is_sub;
   logic [WIDTH-1:0]   b_eff;
   logic [WIDTH:0]     sum;
   logic [SHW-1:0]     amt;

   assign in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
   assign accept    = in_valid && in_ready;
   assign out_valid = (state_q == S_DONE);
   assign result    = result_q;
   assign carryout  = carry_q;
   assign overflow  = ovf_q;
   assign zero      = zero_q;
   assign illegal   = ill_q;

   // SUB reuses the adder as A + ~B + 1, so carry-out means "no borrow"
   assign is_sub = (command == C_SUB);
   assign b_eff  = is_sub ? ~operandB : operandB;
   assign sum    = {1'b0, operandA} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
   assign amt    = operandB[SHW-1:0];

   always_comb begin
      res_d   = '0;
      carry_d = 1'b0;
      ovf_d   = 1'b0;
      ill_d   = 1'b0;
      case (command)
         C_ADD, C_SUB: begin
            res_d   = sum[WIDTH-1:0];
            carry_d = sum[WIDTH];
            ovf_d   = (operandA[WIDTH-1] == b_eff[WIDTH-1]) &&
                      (sum[WIDTH-1] != operandA[WIDTH-1]);
         end
         // signed compare directly rather than via the subtractor sign, so overflow cannot corrupt it
         C_SLT:  res_d = {{(WIDTH-1){1'b0}}, ($signed(operandA) < $signed(operandB))};
         C_XOR:  res_d = operandA ^ operandB;
         C_AND:  res_d = operandA & operandB;
         C_NAND: res_d = ~(operandA & operandB);
         C_NOR:  res_d = ~(operandA | operandB);
         C_OR:   res_d = operandA | operandB;
         C_SLL:  res_d = operandA << amt;
         C_SRL:  res_d = operandA >> amt;
         C_SRA:  res_d = $signed(operandA) >>> amt;
`ifdef SEQ_ALU_MUL_EN
         C_MUL:  res_d = '0;
`endif
         default: ill_d = 1'b1;
      endcase
   end

`ifdef SEQ_ALU_MUL_EN
   logic [2*WIDTH-1:0] acc_q;
   logic [2*WIDTH-1:0] mcand_q;
   logic [WIDTH-1:0]   mplier_q;
   logic [SHW-1:0]     cnt_q;
   logic [2*WIDTH-1:0] acc_d;

   assign acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         result_q <= '0;
         carry_q  <= 1'b0;
         ovf_q    <= 1'b0;
         zero_q   <= 1'b1;
         ill_q    <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
`endif
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (accept) begin
`ifdef SEQ_ALU_MUL_EN
                  if (command == C_MUL) begin
                     state_q  <= S_MULT;
                     acc_q    <= '0;
                     mcand_q  <= {{WIDTH{1'b0}}, operandA};
                     mplier_q <= operandB;
                     cnt_q    <= '0;
                  end else
`endif
                  begin
                     state_q  <= S_DONE;
                     result_q <= res_d;
                     carry_q  <= carry_d;
                     ovf_q    <= ovf_d;
                     zero_q   <= (res_d == '0);
                     ill_q    <= ill_d;
                  end
               end else if ((state_q == S_DONE) && out_ready) begin
                  state_q <= S_IDLE;
               end
            end
`ifdef SEQ_ALU_MUL_EN
            // one multiplier bit per cycle; the WIDTH-th step writes the result
            S_MULT: begin
               acc_q    <= acc_d;
               mcand_q  <= mcand_q << 1;
               mplier_q <= mplier_q >> 1;
               cnt_q    <= cnt_q + SHW'(1);
               if (cnt_q == SHW'(WIDTH - 1)) begin
                  state_q  <= S_DONE;
                  result_q <= acc_d[WIDTH-1:0];
                  carry_q  <= 1'b0;
                  ovf_q    <= |acc_d[2*WIDTH-1:WIDTH];
                  zero_q   <= (acc_d[WIDTH-1:0] == '0);
                  ill_q    <= 1'b0;
               end
            end
`endif
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_alu.sv
// Randomized bench for seq_alu: scoreboard against an arithmetic model, plus directed cases.
// Covers a WIDTH=32 instance and a WIDTH=8 instance sharing clock and reset.
module tb_seq_alu;
   localparam int W  = 32;
   localparam int W8 = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          in_valid, in_ready, out_valid, out_ready;
   logic [3:0]    command;
   logic [W-1:0]  opa, opb, result;
   logic          carryout, overflow, zero, illegal;

   logic          in_valid8, in_ready8, out_valid8, out_ready8;
   logic [3:0]    command8;
   logic [W8-1:0] opa8, opb8, result8;
   logic          carryout8, overflow8, zero8, illegal8;

   always #5 clk = ~clk;

   seq_alu #(.WIDTH(W)) u_dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .command(command), .operandA(opa), .operandB(opb),
      .out_valid(out_valid), .out_ready(out_ready), .result(result),
      .carryout(carryout), .overflow(overflow), .zero(zero), .illegal(illegal));

   seq_alu #(.WIDTH(W8)) u_dut8 (
      .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
      .command(command8), .operandA(opa8), .operandB(opb8),
      .out_valid(out_valid8), .out_ready(out_ready8), .result(result8),
      .carryout(carryout8), .overflow(overflow8), .zero(zero8), .illegal(illegal8));

   typedef struct packed {
      logic [31:0] r;
      logic        c, o, z, il;
   } exp_t;

   typedef struct {
      exp_t       e;
      int         due;
      logic [3:0] cmd;
   } item_t;

   int    total = 0;
   int    bad   = 0;
   int    cyc   = 0;
   item_t scb[$];
   bit    seen  = 0;
   bit    rand_rdy = 0;

   always @(posedge clk) cyc++;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic bit is_mul(input logic [3:0] c);
`ifdef SEQ_ALU_MUL_EN
      return c == 4'd11;
`else
      return 1'b0;
`endif
   endfunction

   // Reference: plain integer arithmetic on w-bit values held in 64-bit variables
   function automatic exp_t model(input int w, input logic [3:0] c,
                                  input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      longint unsigned m, ua, ub, full;
      longint sa, sbv, s, hi, lo;
      int amt;
      m   = (64'd1 << w) - 64'd1;
      ua  = {32'd0, a} & m;
      ub  = {32'd0, b} & m;
      sa  = ua[w-1] ? longint'(ua) - longint'(64'd1 << w) : longint'(ua);
      sbv = ub[w-1] ? longint'(ub) - longint'(64'd1 << w) : longint'(ub);
      hi  = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo  = -(64'sd1 <<< (w - 1));
      amt = int'(ub & ((64'd1 << $clog2(w)) - 64'd1));
      e   = '0;
      case (c)
         4'd0: begin
            full = ua + ub;
            e.r  = 32'(full & m);
            e.c  = full > m;
            s    = sa + sbv;
            e.o  = (s > hi) || (s < lo);
         end
         4'd1: begin
            e.r = 32'((ua - ub) & m);
            e.c = ua >= ub;
            s   = sa - sbv;
            e.o = (s > hi) || (s < lo);
         end
         4'd2:  e.r = 32'(ua ^ ub);
         4'd3:  e.r = (sa < sbv) ? 32'd1 : 32'd0;
         4'd4:  e.r = 32'(ua & ub);
         4'd5:  e.r = 32'(~(ua & ub) & m);
         4'd6:  e.r = 32'(~(ua | ub) & m);
         4'd7:  e.r = 32'(ua | ub);
         4'd8:  e.r = 32'((ua << amt) & m);
         4'd9:  e.r = 32'(ua >> amt);
         4'd10: e.r = 32'(longint'(sa >>> amt) & m);
`ifdef SEQ_ALU_MUL_EN
         4'd11: begin
            full = ua * ub;
            e.r  = 32'(full & m);
            e.o  = (full >> w) != 0;
         end
`endif
         default: e.il = 1'b1;
      endcase
      e.z = (e.r == 32'd0);
      return e;
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0:       return 32'h0;
         1:       return 32'hffffffff;
         2:       return 32'h80000000;
         3:       return 32'h7fffffff;
         4:       return 32'($urandom_range(0, 40));
         default: return $urandom;
      endcase
   endfunction

   // Scoreboard: latency of each completion and its value when consumed
   always @(negedge clk) begin
      if (!reset) begin
         if (out_valid) begin
            if (scb.size() == 0) chk("spurious_valid", 64'(out_valid), 64'd0);
            else begin
               if (!seen) begin
                  chk("latency", 64'(cyc), 64'(scb[0].due));
                  seen = 1;
               end
               if (out_ready) begin
                  logic [3:0] got_f, exp_f;
                  got_f = {carryout, overflow, zero, illegal};
                  exp_f = {scb[0].e.c, scb[0].e.o, scb[0].e.z, scb[0].e.il};
                  if (scb[0].cmd == 4'd3) begin
                     got_f[3:2] = 2'b00;
                     exp_f[3:2] = 2'b00;
                  end
                  chk("sb_result", 64'(result), 64'(scb[0].e.r));
                  chk("sb_flags", 64'(got_f), 64'(exp_f));
                  void'(scb.pop_front());
                  seen = 0;
               end
            end
         end else if (scb.size() > 0 && !seen && cyc > scb[0].due) begin
            chk("late_valid", 64'(cyc), 64'(scb[0].due));
            seen = 1;
         end
      end
   end

   always @(posedge clk) begin
      if (rand_rdy) begin
         #1 out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   // Called just after a rising edge; returns just after the accepting edge
   task automatic send(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
      int n;
      item_t it;
      n = 0;
      command = c; opa = a; opb = b; in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && n < 200) begin
         n++;
         @(negedge clk);
      end
      if (!in_ready) begin
         chk("accept_timeout", 64'(in_ready), 64'd1);
         in_valid = 1'b0;
         return;
      end
      it.e   = model(W, c, a, b);
      it.due = cyc + 1 + (is_mul(c) ? W : 0);
      it.cmd = c;
      scb.push_back(it);
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (scb.size() > 0 && n < 300) begin
         n++;
         @(negedge clk);
      end
      chk("drain", 64'(scb.size()), 64'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic op8(input logic [3:0] c, input logic [7:0] a, input logic [7:0] b);
      int   n;
      exp_t e;
      n = 0;
      command8 = c; opa8 = a; opb8 = b; in_valid8 = 1'b1;
      @(negedge clk);
      chk("w8_in_ready", 64'(in_ready8), 64'd1);
      @(posedge clk);
      #1 in_valid8 = 1'b0;
      @(negedge clk);
      while (!out_valid8 && n < 40) begin
         n++;
         @(negedge clk);
      end
      e = model(W8, c, {24'd0, a}, {24'd0, b});
      chk("w8_latency", 64'(n), 64'(is_mul(c) ? W8 : 0));
      chk("w8_result", 64'(result8), 64'(e.r[7:0]));
      if (c == 4'd3) chk("w8_flags", 64'({zero8, illegal8}), 64'({e.z, e.il}));
      else chk("w8_flags", 64'({carryout8, overflow8, zero8, illegal8}), 64'({e.c, e.o, e.z, e.il}));
      @(posedge clk);
      #1;
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      int t0, n;
      reset = 1'b1;
      in_valid = 1'b0; command = '0; opa = '0; opb = '0; out_ready = 1'b1;
      in_valid8 = 1'b0; command8 = '0; opa8 = '0; opb8 = '0; out_ready8 = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_state", 64'({out_valid, in_ready, carryout, overflow, zero, illegal}), 64'b010010);
      chk("rst_result", 64'(result), 64'd0);
      chk("rst_w8", 64'({out_valid8, in_ready8, zero8, result8}), 64'({3'b011, 8'd0}));
      @(posedge clk);
      #1;

      // signed overflow on ADD
      send(4'd0, 32'h7fffffff, 32'd1);
      chk("add_ovf_res", 64'(result), 64'h80000000);
      chk("add_ovf_flags", 64'({carryout, overflow, zero}), 64'b010);

      // back-to-back single-cycle ops
      send(4'd1, 32'd6, 32'd2);
      chk("sub_6_2", 64'({carryout, result}), 64'({1'b1, 32'd4}));
      send(4'd1, 32'd6, 32'd10);
      chk("sub_6_10", 64'({carryout, result}), 64'({1'b0, 32'hfffffffc}));
      send(4'd3, 32'hffffffff, 32'd1902983);
      chk("slt_neg", 64'(result), 64'd1);
      send(4'd3, 32'h7fffffff, 32'h80000000);
      chk("slt_ovf", 64'(result), 64'd0);

      // shifts use only the low SHW bits of B
      send(4'd10, 32'h80000010, 32'h24);
      chk("sra", 64'(result), 64'hf8000001);
      send(4'd9, 32'h80000010, 32'h24);
      chk("srl", 64'(result), 64'h08000001);
      drain();

`ifdef SEQ_ALU_MUL_EN
      send(4'd11, 32'h10000, 32'h10000);
      t0 = cyc; n = 0;
      @(negedge clk);
      while (!out_valid && n < 60) begin
         n++;
         @(negedge clk);
      end
      chk("mul_latency", 64'(cyc - t0), 64'(W));
      chk("mul_big", 64'({result, zero, overflow}), 64'({32'd0, 2'b11}));
      @(posedge clk);
      #1;
      send(4'd11, 32'd7, 32'd6);
      drain();
`endif

      // backpressure: result held, no new accept while out_ready is low
      out_ready = 1'b0;
      send(4'd0, 32'd1, 32'd1);
      command = 4'd0; opa = 32'd3; opb = 32'd4; in_valid = 1'b1;
      repeat (5) begin
         @(negedge clk);
         chk("bp_hold", 64'({out_valid, in_ready, result}), 64'({2'b10, 32'd2}));
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      send(4'd0, 32'd3, 32'd4);
      chk("bp_next", 64'(result), 64'd7);
      drain();

      // reset in the middle of a multiply (plain op when the multiplier is absent)
      send(4'd11, 32'hdeadbeef, 32'h12345);
      repeat (9) @(posedge clk);
      #1 reset = 1'b1;
      scb.delete();
      seen = 0;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("mid_rst", 64'({out_valid, in_ready, zero, result}), 64'({3'b011, 32'd0}));
      @(posedge clk);
      #1;

      send(4'd13, 32'd5, 32'd6);
      chk("illegal", 64'({result, carryout, overflow, zero, illegal}), 64'({32'd0, 4'b0011}));
      send(4'd11, 32'd3, 32'd5);
      drain();

      // randomized stream with random consumer stalls
      rand_rdy = 1;
      for (int i = 0; i < 400; i++) begin
         send(4'($urandom_range(0, 15)), pick(), pick());
      end
      rand_rdy = 0;
      @(posedge clk);
      #1 out_ready = 1'b1;
      drain();

      // narrow instance
      op8(4'd0, 8'hff, 8'h01);
      chk("w8_add_carry", 64'({carryout8, result8}), 64'h100);
      op8(4'd11, 8'h10, 8'h10);
      for (int i = 0; i < 60; i++) begin
         op8(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, registered ALU with valid/ready handshakes. It is the successor to the single-cycle 32-bit combinational ALU and keeps its eight command encodings and flag semantics. It adds a configurable data width, logical and arithmetic shifts, and an optional iterative shift-add multiplier. It sits between the CPU decode/operand-fetch stage and writeback, and holds one operation in flight.

## Interface
- `WIDTH`, 32: operand/result width in bits; must be ≥ 4.
- `SHW`, `$clog2(WIDTH)`: shift-amount width; derived, do not override.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high.
- `in_valid`  in  1  operation request.
- `in_ready`  out  1  block can accept a request.
- `command`  in  4  operation code.
- `operandA`  in  WIDTH  first operand.
- `operandB`  in  WIDTH  second operand / shift amount.
- `out_valid`  out  1  result registers hold a completed operation.
- `out_ready`  in  1  consumer takes the result.
- `result`  out  WIDTH  registered result.
- `carryout`  out  1  registered carry.
- `overflow`  out  1  registered overflow.
- `zero`  out  1  registered, high iff `result == 0`.
- `illegal`  out  1  registered, high if the command was unsupported.

Clock/reset: one clock; reset is synchronous and active-high (`clk`, `reset`).

## Operation
- Commands:
  - 0 ADD, 1 SUB, 2 XOR, 3 SLT, 4 AND, 5 NAND, 6 NOR, 7 OR.
  - 8 SLL, 9 SRL, 10 SRA, 11 MUL.
  - 12–15 are illegal.
- ADD/SUB:
  - `carryout` is the bit-WIDTH carry of A + B or A + ~B + 1. SUB with A ≥ B unsigned gives `carryout` = 1.
  - `overflow` is two's-complement signed overflow.
- SLT: `result` = 1 if A < B signed, else 0. Correct even when A − B overflows.
- Logic ops and shifts: `carryout` = `overflow` = 0.
- Shifts: amount = `operandB[SHW-1:0]`. Upper bits of B are ignored. SRA replicates A's MSB.
- MUL:
  - `result` = low WIDTH bits of the unsigned product A × B.
  - `overflow` = 1 iff the high WIDTH bits are nonzero. `carryout` = 0.
- Illegal command: `result` = 0, `zero` = 1, `carryout` = `overflow` = 0, `illegal` = 1. `illegal` = 0 for every other completion.
- Operands and command are captured on acceptance. Input changes afterwards have no effect.
- State machine:
  - IDLE: `in_ready` = 1. On accept, a single-cycle command → DONE; MUL → MULT with counter = 0.
  - MULT: one shift-add step per cycle. Counter increments; at counter = WIDTH−1 → DONE.
  - DONE: `out_valid` = 1 and `in_ready` = `out_ready`. With `out_ready` && `in_valid`, the result is consumed and the new request accepted in the same cycle (next state per its command). With `out_ready` && !`in_valid` → IDLE. With `!out_ready`, hold all outputs stable.
- Reset (any state, including mid-MULT): → IDLE. The partial product is discarded.
- Reset values: `out_valid` = 0, `in_ready` = 1 in the cycle after reset, `result` = 0, `carryout` = 0, `overflow` = 0, `zero` = 1, `illegal` = 0.

## Timing
- Accept = `in_valid` && `in_ready` at a rising edge E.
- Single-cycle commands: `out_valid` and results are visible right after edge E; latency 1.
- MUL: `out_valid` rises after edge E+WIDTH; latency WIDTH+1.
- Throughput: one single-cycle op per clock while `out_ready` is held high.
- All outputs are driven directly from registers; there is no combinational path from `operandA`/`operandB`/`command` to any output.
- `in_ready` combinationally depends on `out_ready` in DONE only.

## Configuration
- `SEQ_ALU_MUL_EN` defined:
  - MUL is implemented as above, with the MULT state, counter and 2×WIDTH accumulator.
- `SEQ_ALU_MUL_EN` undefined:
  - Command 11 is treated as illegal: latency 1, `illegal` = 1, `result` = 0.
  - No MULT state or multiplier hardware is built.

## Test plan
1. WIDTH=32: ADD 0x7fffffff + 1 with `out_ready` = 1 → one cycle later `result` = 0x80000000, `overflow` = 1, `carryout` = 0, `zero` = 0.
2. WIDTH=32, back-to-back: SUB 6−2, then SUB 6−10, then SLT −1 < 1902983, one per clock → results 4 (`carryout` = 1), 0xfffffffc (`carryout` = 0), 1 on consecutive cycles.
3. Shifts: SRA 0x80000010 by B = 0x24 (amount 4) → 0xf8000001. SRL of the same operands → 0x08000001.
4. `SEQ_ALU_MUL_EN` defined, WIDTH=32:
   - MUL 0x10000 × 0x10000 → `out_valid` after 33 cycles, `result` = 0, `zero` = 1, `overflow` = 1.
   - MUL 7 × 6 → 42, `overflow` = 0.
5. Backpressure: `out_ready` = 0 for 5 cycles after ADD 1+1 → `result` holds 2 and `in_ready` = 0 throughout. Raising `out_ready` with a new ADD 3+4 pending → next result 7.
6. Reset and illegal command:
   - Assert `reset` 10 cycles into a MUL → next cycle `out_valid` = 0, `result` = 0, `zero` = 1, `in_ready` = 1.
   - Command 13 → `illegal` = 1, `result` = 0.
   - WIDTH=8 rerun: ADD 0xff + 1 → 0, `carryout` = 1.
